// File: rtl/hpu_axil_ctrl_if.sv
// AXI4-Lite bus bundle (32-bit address/data) between the PS master and the HPU control block.
interface hpu_axil_ctrl_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/hpu_axil_ctrl.sv
// AXI4-Lite control/status slave for the HPU top: CTRL, STATUS, MATW_LIMIT, SCRATCH, PARAM bank.
// Define HPU_CTRL_IRQ_EN to add the IRQ_EN register (0x00C) and the irq output.
module hpu_axil_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int NUM_PARAM = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  hpu_axil_ctrl_if.slave            s_axi,
  input  logic [CNT_W-1:0]          mat_cnt,
  input  logic                      done_in,
  output logic                      matw,
  output logic                      run,
  output logic                      last,
`ifdef HPU_CTRL_IRQ_EN
  output logic                      irq,
`endif
  output logic [NUM_PARAM*32-1:0]   param
);

  typedef enum logic [2:0] {IDLE, GOT_AW, GOT_W, BRESP, RD1, RD2} state_t;

  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] IDX_CTRL    = IW'(32'h000);
  localparam logic [IW-1:0] IDX_STATUS  = IW'(32'h001);
  localparam logic [IW-1:0] IDX_LIMIT   = IW'(32'h002);
  localparam logic [IW-1:0] IDX_SCRATCH = IW'(32'h004);
  localparam logic [IW-1:0] IDX_PARAM   = IW'(32'h040);
`ifdef HPU_CTRL_IRQ_EN
  localparam logic [IW-1:0] IDX_IRQ_EN  = IW'(32'h003);
`endif

  state_t            state_r;
  logic [IW-1:0]     addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic              wr_pend_r;
  logic              bvalid_r;
  logic              rvalid_r;
  logic [31:0]       rdata_r;

  logic              matw_r;
  logic              run_r;
  logic              last_r;
  logic              done_r;
  logic              matw_done_r;
  logic [CNT_W-1:0]  matw_limit_r;
  logic [31:0]       scratch_r;
  logic [31:0]       param_r [NUM_PARAM];
`ifdef HPU_CTRL_IRQ_EN
  logic [1:0]        irq_en_r;
  logic              irq_r;
  logic              irq_en_wr_s;
`endif

  logic              wr_en_s;
  logic              ctrl_wr_s;
  logic              status_wr_s;
  logic              limit_wr_s;
  logic              scratch_wr_s;
  logic              cnt_hit_s;
  logic [31:0]       limit_merge_s;
  logic [31:0]       scratch_merge_s;
  logic [31:0]       rd_param_s;
  logic [31:0]       rd_data_s;
  logic              unused_bits_s;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res_v;
    for (int i = 0; i < 4; i++) begin
      res_v[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res_v;
  endfunction

  // Read may only be accepted from IDLE when no write is being presented, so writes win.
  assign s_axi.awready = (state_r == IDLE) || (state_r == GOT_W);
  assign s_axi.wready  = (state_r == IDLE) || (state_r == GOT_AW);
  assign s_axi.arready = (state_r == IDLE) && !s_axi.awvalid && !s_axi.wvalid;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rdata   = rdata_r;

  assign unused_bits_s = ^{s_axi.awaddr[31:ADDR_W], s_axi.awaddr[1:0],
                           s_axi.araddr[31:ADDR_W], s_axi.araddr[1:0], limit_merge_s};

  // Write/read decode; register updates happen only on the first BRESP cycle.
  always_comb begin
    wr_en_s         = (state_r == BRESP) && wr_pend_r;
    ctrl_wr_s       = wr_en_s && (addr_r == IDX_CTRL);
    status_wr_s     = wr_en_s && (addr_r == IDX_STATUS);
    limit_wr_s      = wr_en_s && (addr_r == IDX_LIMIT);
    scratch_wr_s    = wr_en_s && (addr_r == IDX_SCRATCH);
`ifdef HPU_CTRL_IRQ_EN
    irq_en_wr_s     = wr_en_s && (addr_r == IDX_IRQ_EN);
`endif
    cnt_hit_s       = matw_r && (mat_cnt == matw_limit_r);
    limit_merge_s   = strb_merge(32'(matw_limit_r), wdata_r, wstrb_r);
    scratch_merge_s = strb_merge(scratch_r, wdata_r, wstrb_r);
  end

  // Read data mux; anything not matched falls through to the parameter bank, else 0.
  always_comb begin
    rd_param_s = 32'h0;
    for (int k = 0; k < NUM_PARAM; k++) begin
      rd_param_s = rd_param_s | ((addr_r == IDX_PARAM + IW'(k)) ? param_r[k] : 32'h0);
    end
    case (addr_r)
      IDX_CTRL:    rd_data_s = {29'h0, last_r, run_r, matw_r};
      IDX_STATUS:  rd_data_s = {28'h0, matw_done_r, done_r, run_r, matw_r};
      IDX_LIMIT:   rd_data_s = 32'(matw_limit_r);
      IDX_SCRATCH: rd_data_s = scratch_r;
`ifdef HPU_CTRL_IRQ_EN
      IDX_IRQ_EN:  rd_data_s = {30'h0, irq_en_r};
`endif
      default:     rd_data_s = rd_param_s;
    endcase
  end

  // AXI-Lite handshake FSM with registered BVALID/RVALID/RDATA.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      wdata_r   <= 32'h0;
      wstrb_r   <= 4'h0;
      wr_pend_r <= 1'b0;
      bvalid_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (s_axi.awvalid && s_axi.wvalid) begin
            addr_r    <= s_axi.awaddr[ADDR_W-1:2];
            wdata_r   <= s_axi.wdata;
            wstrb_r   <= s_axi.wstrb;
            wr_pend_r <= 1'b1;
            bvalid_r  <= 1'b1;
            state_r   <= BRESP;
          end else if (s_axi.awvalid) begin
            addr_r    <= s_axi.awaddr[ADDR_W-1:2];
            state_r   <= GOT_AW;
          end else if (s_axi.wvalid) begin
            wdata_r   <= s_axi.wdata;
            wstrb_r   <= s_axi.wstrb;
            state_r   <= GOT_W;
          end else if (s_axi.arvalid) begin
            addr_r    <= s_axi.araddr[ADDR_W-1:2];
            state_r   <= RD1;
          end else begin
            state_r   <= IDLE;
          end
        end
        GOT_AW: begin
          if (s_axi.wvalid) begin
            wdata_r   <= s_axi.wdata;
            wstrb_r   <= s_axi.wstrb;
            wr_pend_r <= 1'b1;
            bvalid_r  <= 1'b1;
            state_r   <= BRESP;
          end
        end
        GOT_W: begin
          if (s_axi.awvalid) begin
            addr_r    <= s_axi.awaddr[ADDR_W-1:2];
            wr_pend_r <= 1'b1;
            bvalid_r  <= 1'b1;
            state_r   <= BRESP;
          end
        end
        BRESP: begin
          wr_pend_r <= 1'b0;
          if (s_axi.bready) begin
            bvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        RD1: begin
          rdata_r  <= rd_data_s;
          rvalid_r <= 1'b1;
          state_r  <= RD2;
        end
        RD2: begin
          if (s_axi.rready) begin
            rvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Register bank: CTRL write overrides matw auto-clear, done set overrides its W1C.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      matw_r       <= 1'b0;
      run_r        <= 1'b0;
      last_r       <= 1'b0;
      done_r       <= 1'b0;
      matw_done_r  <= 1'b0;
      matw_limit_r <= '0;
      scratch_r    <= 32'h0;
      for (int k = 0; k < NUM_PARAM; k++) begin
        param_r[k] <= 32'h0;
      end
`ifdef HPU_CTRL_IRQ_EN
      irq_en_r     <= 2'b00;
      irq_r        <= 1'b0;
`endif
    end else begin
      if (ctrl_wr_s) begin
        if (wstrb_r[0]) begin
          matw_r <= wdata_r[0];
          run_r  <= wdata_r[1];
          last_r <= wdata_r[2];
        end
      end else if (cnt_hit_s) begin
        matw_r <= 1'b0;
      end

      if (!ctrl_wr_s && cnt_hit_s) begin
        matw_done_r <= 1'b1;
      end else if (status_wr_s && wstrb_r[0] && wdata_r[3]) begin
        matw_done_r <= 1'b0;
      end

      if (done_in && run_r) begin
        done_r <= 1'b1;
      end else if (status_wr_s && wstrb_r[0] && wdata_r[2]) begin
        done_r <= 1'b0;
      end

      if (limit_wr_s) begin
        matw_limit_r <= limit_merge_s[CNT_W-1:0];
      end
      if (scratch_wr_s) begin
        scratch_r <= scratch_merge_s;
      end
      for (int k = 0; k < NUM_PARAM; k++) begin
        if (wr_en_s && (addr_r == IDX_PARAM + IW'(k))) begin
          param_r[k] <= strb_merge(param_r[k], wdata_r, wstrb_r);
        end
      end
`ifdef HPU_CTRL_IRQ_EN
      if (irq_en_wr_s && wstrb_r[0]) begin
        irq_en_r <= wdata_r[1:0];
      end
      irq_r <= |(irq_en_r & {matw_done_r, done_r});
`endif
    end
  end

  assign matw = matw_r;
  assign run  = run_r;
  assign last = last_r;
`ifdef HPU_CTRL_IRQ_EN
  assign irq  = irq_r;
`endif

  for (genvar k = 0; k < NUM_PARAM; k++) begin : g_param
    assign param[32*k +: 32] = param_r[k];
  end

endmodule
